// File: rtl/sw_debounce.sv
// Switch debouncer: per-bit synchronizer followed by a saturating stability counter.
// Optional per-bit rise/fall strobes are enabled with the SW_DEBOUNCE_EDGE_EN macro.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_STABLE  | sync matches sw_out; counter held at zero
// ST_PENDING | sync differs from sw_out; counter advancing
// ST_COMMIT  | difference has lasted CNT_MAX cycles; sw_out takes sync
module sw_debounce #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               CNT_MAX     = 50000,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic             changed
`ifdef SW_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  localparam int             CW       = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    ST_STABLE,
    ST_PENDING,
    ST_COMMIT
  } bit_state_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  bit_state_e       state  [WIDTH];
  logic [WIDTH-1:0] out_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RESET_VAL;
    end else begin
      sync_q[0] <= sw_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_out  <= RESET_VAL;
      changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sw_out  <= out_d;
      changed <= |(out_d ^ sw_out);
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Any return of sync to sw_out before commit drops the count back to zero.
  always_comb begin
    out_d = sw_out;
    for (int i = 0; i < WIDTH; i++) begin
      state[i] = ST_STABLE;
      cnt_d[i] = '0;
      if (sync[i] != sw_out[i]) begin
        state[i] = (cnt_q[i] == CNT_LAST) ? ST_COMMIT : ST_PENDING;
      end
      case (state[i])
        ST_PENDING: cnt_d[i] = cnt_q[i] + CW'(1);
        ST_COMMIT:  out_d[i] = sync[i];
        default:    cnt_d[i] = '0;
      endcase
    end
  end

`ifdef SW_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= out_d & ~sw_out;
      fall <= ~out_d & sw_out;
    end
  end
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with CNT_MAX=4, SYNC_STAGES=2, RESET_VAL=0.
module tb_sw_debounce;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] sw_in = 8'h00;
  logic [7:0] sw_out;
  logic       changed;
`ifdef SW_DEBOUNCE_EDGE_EN
  logic [7:0] rise;
  logic [7:0] fall;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sw_debounce #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .CNT_MAX(4),
    .RESET_VAL(8'h00)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sw_in(sw_in),
    .sw_out(sw_out),
    .changed(changed)
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    .rise(rise),
    .fall(fall)
`endif
  );

  typedef struct {
    logic [7:0] din;
    int         hold;
    logic [7:0] out;
    int         pulses;
    int         lat;
    logic [7:0] rise;
    logic [7:0] fall;
  } vec_t;

  vec_t tbl [11];
  vec_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance hold cycles from the current negedge, sampling on each negedge.
  task automatic observe(input int hold, input logic [7:0] start_out,
                         output int pulses, output int first_chg, output int first_out,
                         output logic [7:0] rs, output logic [7:0] fs);
    pulses = 0; first_chg = 0; first_out = 0; rs = 8'h00; fs = 8'h00;
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (changed === 1'b1) begin
        pulses++;
        if (first_chg == 0) first_chg = k;
      end
      if (first_out == 0 && sw_out !== start_out) first_out = k;
`ifdef SW_DEBOUNCE_EDGE_EN
      rs |= rise;
      fs |= fall;
      check("changed_vs_edges", {31'd0, changed}, {31'd0, |(rise | fall)});
`endif
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    int p, fc, fo;
    logic [7:0] rs, fs, start;
    start = sw_out;
    sw_in = v.din;
    exp_q.push_back(v);
    observe(v.hold, start, p, fc, fo, rs, fs);
    e = exp_q.pop_front();
    check({tag, "_sw_out"}, {24'd0, sw_out}, {24'd0, e.out});
    check({tag, "_pulses"}, p, e.pulses);
    check({tag, "_changed_cycle"}, fc, e.lat);
    check({tag, "_out_cycle"}, fo, e.lat);
`ifdef SW_DEBOUNCE_EDGE_EN
    check({tag, "_rise"}, {24'd0, rs}, {24'd0, e.rise});
    check({tag, "_fall"}, {24'd0, fs}, {24'd0, e.fall});
`endif
  endtask

  logic [10:0] chg_map;
  logic [7:0]  out_k6, out_k7;
`ifdef SW_DEBOUNCE_EDGE_EN
  logic [7:0]  fall_k6, fall_k7;
`endif

  initial begin
    //           din    hold out    pulses lat rise   fall
    tbl[0]  = '{8'h00, 20, 8'h00, 0, 0, 8'h00, 8'h00};
    tbl[1]  = '{8'h01, 10, 8'h01, 1, 6, 8'h01, 8'h00};
    tbl[2]  = '{8'h00, 10, 8'h00, 1, 6, 8'h00, 8'h01};
    tbl[3]  = '{8'hA5, 10, 8'hA5, 1, 6, 8'hA5, 8'h00};
    tbl[4]  = '{8'h00, 10, 8'h00, 1, 6, 8'h00, 8'hA5};
    tbl[5]  = '{8'hFF,  3, 8'h00, 0, 0, 8'h00, 8'h00};
    tbl[6]  = '{8'h00, 10, 8'h00, 0, 0, 8'h00, 8'h00};
    tbl[7]  = '{8'h08,  3, 8'h00, 0, 0, 8'h00, 8'h00};
    tbl[8]  = '{8'h00,  1, 8'h00, 0, 0, 8'h00, 8'h00};
    tbl[9]  = '{8'h08, 12, 8'h08, 1, 6, 8'h08, 8'h00};
    tbl[10] = '{8'hA5, 10, 8'hA5, 1, 6, 8'hA5, 8'h08};

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_sw_out", {24'd0, sw_out}, 32'h0);
    check("reset_changed", {31'd0, changed}, 32'h0);
`ifdef SW_DEBOUNCE_EDGE_EN
    check("reset_rise", {24'd0, rise}, 32'h0);
    check("reset_fall", {24'd0, fall}, 32'h0);
`endif
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a pending count, starting from sw_out=A5.
    sw_in = 8'hFF;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    check("midrst_sw_out_now", {24'd0, sw_out}, 32'h0);
    check("midrst_changed_now", {31'd0, changed}, 32'h0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst_sw_out_held", {24'd0, sw_out}, 32'h0);
      check("midrst_changed_held", {31'd0, changed}, 32'h0);
    end
    reset_n = 1'b1;
    run_vec('{8'hFF, 10, 8'hFF, 1, 6, 8'hFF, 8'h00}, "after_rst");

    // Commits on different bits in consecutive cycles give back-to-back pulses.
    chg_map = '0; out_k6 = '0; out_k7 = '0;
`ifdef SW_DEBOUNCE_EDGE_EN
    fall_k6 = '0; fall_k7 = '0;
`endif
    sw_in = 8'h7F;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) sw_in = 8'h3F;
      chg_map[k] = changed;
      if (k == 6) out_k6 = sw_out;
      if (k == 7) out_k7 = sw_out;
`ifdef SW_DEBOUNCE_EDGE_EN
      if (k == 6) fall_k6 = fall;
      if (k == 7) fall_k7 = fall;
`endif
    end
    check("b2b_changed_map", {21'd0, chg_map}, 32'h0C0);
    check("b2b_out_k6", {24'd0, out_k6}, 32'h7F);
    check("b2b_out_k7", {24'd0, out_k7}, 32'h3F);
    check("b2b_out_end", {24'd0, sw_out}, 32'h3F);
`ifdef SW_DEBOUNCE_EDGE_EN
    check("b2b_fall_k6", {24'd0, fall_k6}, 32'h80);
    check("b2b_fall_k7", {24'd0, fall_k7}, 32'h40);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
